scfifo_param: RTL and testbench

Parametrised single-clock FIFO, the successor to the fixed 8x32 transfer FIFO between the ROM-side write controller and the RAM-side read controller. It generalises width and depth and adds:
- selectable normal or show-ahead read mode
- programmable almost-full and almost-empty thresholds
- a fill-level count
- sticky overflow and underflow error flags
- a synchronous flush

It sits between a producer control logic block and a consumer control logic block that share one clock.

---
 rtl/scfifo_param_pkg.sv | 16 +
 rtl/sdpram_param.sv | 45 ++++
 rtl/scfifo_param.sv | 168 ++++++++++++++++
 tb/tb_scfifo_param.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/scfifo_param_pkg.sv
// rtl/scfifo_param_pkg.sv - shared types and helpers for the parametrised single-clock FIFO
// Purpose: read-mode enumeration and the fill-level counter width helper.
// Ports: none (package).
package scfifo_param_pkg;

  typedef enum logic {
    NORMAL    = 1'b0,
    SHOWAHEAD = 1'b1
  } fifo_mode_e;

  // The counter must represent 0..2**addr_w inclusive, hence one extra bit.
  function automatic int unsigned usedw_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sdpram_param.sv
// rtl/sdpram_param.sv - simple dual-port RAM, one write port, one registered read port
// Purpose: storage array for scfifo_param.
// Ports:
//   clk_i      clock, all logic on rising edge
//   reset_i    synchronous active-high reset of the read data register only
//   wr_en_i    write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_en_i    read enable; rd_data_o updates only when set
//   rd_addr_i  read address
//   rd_data_o  registered read data (old data on a same-address write)
module sdpram_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/scfifo_param.sv
// rtl/scfifo_param.sv - parametrised single-clock FIFO with show-ahead, thresholds and sticky errors
// Purpose: producer/consumer FIFO on one clock; occupancy kept in a usedw counter.
// Ports:
//   clk_i           clock, all logic on rising edge
//   reset_i         synchronous active-high reset
//   clear_i         synchronous flush of pointers, count and sticky flags
//   wrreq_i/data_i  write request and data
//   rdreq_i         read request (normal) or pop (show-ahead)
//   q_o             read data / head word
//   full_o, empty_o, almost_full_o, almost_empty_o   registered status flags
//   usedw_o         stored word count 0..2**ADDR_W
//   overflow_o      sticky: write attempted while full
//   underflow_o     sticky: read attempted while empty
module scfifo_param
  import scfifo_param_pkg::fifo_mode_e, scfifo_param_pkg::usedw_width;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int SHOWAHEAD = 0,
  parameter int AF_LEVEL  = 6,
  parameter int AE_LEVEL  = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            clear_i,
  input  logic                            wrreq_i,
  input  logic [DATA_W-1:0]               data_i,
  input  logic                            rdreq_i,
  output logic [DATA_W-1:0]               q_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            almost_full_o,
  output logic                            almost_empty_o,
  output logic [usedw_width(ADDR_W)-1:0]  usedw_o,
  output logic                            overflow_o,
  output logic                            underflow_o
);

  localparam int UW = usedw_width(ADDR_W);
  localparam logic [UW-1:0] DEPTH_U = UW'(2**ADDR_W);
  localparam logic [UW-1:0] AF_U    = UW'(AF_LEVEL);
  localparam logic [UW-1:0] AE_U    = UW'(AE_LEVEL);
  localparam fifo_mode_e MODE = (SHOWAHEAD != 0) ? scfifo_param_pkg::SHOWAHEAD
                                                 : scfifo_param_pkg::NORMAL;

  if (ADDR_W < 1 || AE_LEVEL <= 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL >= 2**ADDR_W) begin : g_bad_params
    $error("scfifo_param: illegal ADDR_W/AE_LEVEL/AF_LEVEL combination");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]     usedw_q, usedw_d;
  logic              full_q, empty_q, af_q, ae_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_acc, rd_acc;

  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              byp_load;
  logic [DATA_W-1:0] byp_q;
  logic              byp_sel_q, byp_sel_d;

  // Pointer, count and sticky-flag next state. Acceptance uses the registered
  // full/empty so a request is judged against the state the producer saw.
  always_comb begin
    wr_acc   = wrreq_i && !full_q  && !clear_i;
    rd_acc   = rdreq_i && !empty_q && !clear_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   usedw_d = usedw_q + 1'b1;
        2'b01:   usedw_d = usedw_q - 1'b1;
        default: usedw_d = usedw_q;
      endcase
      if (wrreq_i && full_q)  ovf_d = 1'b1;
      if (rdreq_i && empty_q) unf_d = 1'b1;
    end
  end

  // Read-side steering. Normal mode: the RAM output register is q_o and only
  // advances on an accepted read. Show-ahead: the RAM prefetches the next head
  // address; if that very word is being written this cycle the RAM would return
  // stale data, so the write data is captured in a bypass register instead.
  // Holding both registers otherwise keeps q_o stable across clear_i.
  always_comb begin
    ram_rd_en   = 1'b0;
    ram_rd_addr = rd_ptr_q;
    byp_load    = 1'b0;
    byp_sel_d   = byp_sel_q;
    if (MODE == scfifo_param_pkg::NORMAL) begin
      ram_rd_en = rd_acc;
    end else begin
      ram_rd_addr = rd_ptr_d;
      if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
        byp_load  = 1'b1;
        byp_sel_d = 1'b1;
      end else if (rd_acc && (usedw_d != '0)) begin
        ram_rd_en = 1'b1;
        byp_sel_d = 1'b0;
      end
    end
  end

  sdpram_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_i),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      byp_q     <= '0;
      byp_sel_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      full_q    <= (usedw_d == DEPTH_U);
      empty_q   <= (usedw_d == '0);
      af_q      <= (usedw_d >= AF_U);
      ae_q      <= (usedw_d <= AE_U);
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      byp_sel_q <= byp_sel_d;
      if (byp_load) byp_q <= data_i;
    end
  end

  assign q_o            = byp_sel_q ? byp_q : ram_rd_data;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign usedw_o        = usedw_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_scfifo_param.sv
// tb/tb_scfifo_param.sv - self-checking bench for scfifo_param in normal and show-ahead modes
module tb_scfifo_param;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [DW-1:0] data  = '0;

  logic [DW-1:0] q_n, q_s;
  logic          full_n, empty_n, af_n, ae_n, ovf_n, unf_n;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic [AW:0]   usedw_n, usedw_s;

  scfifo_param #(.DATA_W(DW), .ADDR_W(AW), .SHOWAHEAD(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_norm (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .wrreq_i(wrreq), .data_i(data),
    .rdreq_i(rdreq), .q_o(q_n), .full_o(full_n), .empty_o(empty_n),
    .almost_full_o(af_n), .almost_empty_o(ae_n), .usedw_o(usedw_n),
    .overflow_o(ovf_n), .underflow_o(unf_n)
  );

  scfifo_param #(.DATA_W(DW), .ADDR_W(AW), .SHOWAHEAD(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_sa (
    .clk_i(clk), .reset_i(reset), .clear_i(clear), .wrreq_i(wrreq), .data_i(data),
    .rdreq_i(rdreq), .q_o(q_s), .full_o(full_s), .empty_o(empty_s),
    .almost_full_o(af_s), .almost_empty_o(ae_s), .usedw_o(usedw_s),
    .overflow_o(ovf_s), .underflow_o(unf_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of stored words plus the observable registers.
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  logic [DW-1:0] m_qn  = '0;
  logic [DW-1:0] m_qs  = '0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit after_reset);
    int sz;
    sz = mq.size();
    check_eq("usedw_n", 32'(usedw_n), 32'(sz));
    check_eq("usedw_s", 32'(usedw_s), 32'(sz));
    check_eq("full_n",  32'(full_n),  32'(sz == DEPTH));
    check_eq("full_s",  32'(full_s),  32'(sz == DEPTH));
    check_eq("empty_n", 32'(empty_n), 32'(sz == 0));
    check_eq("empty_s", 32'(empty_s), 32'(sz == 0));
    check_eq("afull_n", 32'(af_n),    32'(sz >= AF));
    check_eq("afull_s", 32'(af_s),    32'(sz >= AF));
    check_eq("aempty_n", 32'(ae_n),   32'(sz <= AE));
    check_eq("aempty_s", 32'(ae_s),   32'(sz <= AE));
    check_eq("ovf_n",   32'(ovf_n),   32'(m_ovf));
    check_eq("ovf_s",   32'(ovf_s),   32'(m_ovf));
    check_eq("unf_n",   32'(unf_n),   32'(m_unf));
    check_eq("unf_s",   32'(unf_s),   32'(m_unf));
    check_eq("q_normal", q_n, m_qn);
    if (sz > 0 || after_reset) check_eq("q_showahead", q_s, m_qs);
  endtask

  task automatic step(input bit r, input bit c, input bit w, input bit rd, input logic [DW-1:0] d);
    bit was_full, was_empty;
    reset = r; clear = c; wrreq = w; rdreq = rd; data = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_qn = '0; m_qs = '0;
    end else if (c) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
      if (rd && !was_empty) m_qn = mq.pop_front();
      if (w && !was_full) mq.push_back(d);
      if (mq.size() > 0) m_qs = mq[0];
    end
    #1;
    check_all(r);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Fill 0x11..0x88, then a write into a full FIFO
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, DW'(i * 32'h11));
    step(0, 0, 1, 0, 32'h99);

    // Drain all eight, then one read of an empty FIFO
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Show-ahead write into empty FIFO, then pop
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'hA5);
    step(0, 0, 0, 1, 0);

    // Sustained simultaneous traffic at usedw=3, pointers wrap
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, $urandom);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, $urandom);

    // Simultaneous requests when full, then when empty
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, $urandom);
    step(0, 0, 1, 1, 32'hDEAD0001);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 32'hBEEF0002);

    // Clear with pending write at usedw=5 and overflow set
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, $urandom);
    step(0, 0, 1, 0, 32'h12345678);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 32'hCAFE0003);
    step(0, 0, 1, 0, 32'h0000C0DE);

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) step(0, 0, 1, (i % 2) == 1, $urandom);
    step(1, 0, 1, 1, $urandom);
    step(0, 0, 1, 1, 32'h5A5A5A5A);

    // Random traffic with occasional clear and reset
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
